// File: rtl/distance_display_pkg.sv
// Shared types and helpers for the distance bar-graph display.
// Display mode encoding and level-width sizing.
package distance_display_pkg;

   typedef enum logic [1:0] {
      MODE_BAR,
      MODE_DOT,
      MODE_BAR_BLINK,
      MODE_RSVD
   } disp_mode_t;

   function automatic int level_w(input int n_leds);
      return $clog2(n_leds + 1);
   endfunction

endpackage

// File: rtl/distance_avg_filter.sv
// Moving-average filter over the last 2^AVG_LOG2 distance samples.
// The first sample after reset fills the whole window.
module distance_avg_filter
   import distance_display_pkg::*;
#(
   parameter int DIST_W   = 22,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DIST_W-1:0] in_data,
   output logic              out_valid,
   output logic [DIST_W-1:0] out_avg
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = DIST_W + AVG_LOG2;
   localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic [DIST_W-1:0] mem_q [DEPTH];
   logic [SUM_W-1:0]  sum_q;
   logic [PW-1:0]     ptr_q;
   logic              primed_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         sum_q     <= '0;
         ptr_q     <= '0;
         primed_q  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            if (!primed_q) begin
               for (int i = 0; i < DEPTH; i++) mem_q[i] <= in_data;
               sum_q    <= SUM_W'(in_data) << AVG_LOG2;
               primed_q <= 1'b1;
            end else begin
               sum_q <= sum_q - SUM_W'(mem_q[ptr_q])
                              + SUM_W'(in_data);
               mem_q[ptr_q] <= in_data;
               if (ptr_q == PW'(DEPTH - 1)) ptr_q <= '0;
               else                         ptr_q <= ptr_q + PW'(1);
            end
         end
      end
   end

   assign out_avg = DIST_W'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/distance_bargraph_display.sv
// Averaged distance -> LED level with hysteresis, bar/dot/blink decode.
// Three-stage pipeline: average, level map, hysteresis.
module distance_bargraph_display
   import distance_display_pkg::*;
#(
   parameter int DIST_W    = 22,
   parameter int N_LEDS    = 10,
   parameter int SHIFT     = 18,
   parameter int STEP_LOG2 = 1,
   parameter int AVG_LOG2  = 2,
   parameter int HOLD      = 3,
   parameter int BLINK_DIV = 6_250_000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_valid,
   input  logic [DIST_W-1:0]            distance,
   input  logic [1:0]                   mode,
   output logic [N_LEDS-1:0]            led,
   output logic [level_w(N_LEDS)-1:0]   level,
   output logic                         too_close
);

   localparam int LW = level_w(N_LEDS);
   localparam int CW = $clog2(HOLD + 1);
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic              avg_valid;
   logic [DIST_W-1:0] avg;
   logic [DIST_W-1:0] step_s;
   logic [LW-1:0]     raw_d, raw_q;
   logic              raw_valid_q;
   logic [LW-1:0]     level_q, level_d;
   logic [LW-1:0]     cand_q, cand_d;
   logic [CW-1:0]     cnt_q, cnt_d, step_cnt;
   logic [BW-1:0]     blink_cnt_q;
   logic              blink_phase_q;
   logic              is_first, is_jump, is_same, is_step;
   int                raw_i, lvl_i;
   logic [N_LEDS-1:0] bar, dot;
   disp_mode_t        mode_e;

   distance_avg_filter #(
      .DIST_W   (DIST_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sample_valid),
      .in_data   (distance),
      .out_valid (avg_valid),
      .out_avg   (avg)
   );

   // Near objects light more LEDs; far ones saturate at a single LED.
   always_comb begin
      step_s = avg >> (SHIFT + STEP_LOG2);
      if (step_s < DIST_W'(N_LEDS - 1)) raw_d = LW'(N_LEDS) - LW'(step_s);
      else                               raw_d = LW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw_valid_q <= 1'b0;
         raw_q       <= '0;
      end else begin
         raw_valid_q <= avg_valid;
         if (avg_valid) raw_q <= raw_d;
      end
   end

   always_comb begin
      raw_i    = int'(raw_q);
      lvl_i    = int'(level_q);
      is_first = (level_q == '0);
      is_jump  = !is_first && (raw_i >= lvl_i + 2 || lvl_i >= raw_i + 2);
      is_same  = !is_first && (raw_i == lvl_i);
      is_step  = !is_first && !is_jump && !is_same;
   end

   always_comb begin
      level_d  = level_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      step_cnt = (raw_q != cand_q) ? CW'(1) : cnt_q + CW'(1);
      if (raw_valid_q) begin
         unique case (1'b1)
            is_first: level_d = raw_q;
            is_jump: begin
               level_d = raw_q;
               cnt_d   = '0;
            end
            is_same: cnt_d = '0;
            is_step: begin
               cand_d = raw_q;
               if (int'(step_cnt) >= HOLD) begin
                  level_d = raw_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = step_cnt;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level     = level_q;
   assign too_close = (level_q == LW'(N_LEDS));

   // Parked with the LEDs on so the first off-phase is a full period away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (!too_close) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= ~blink_phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BW'(1);
      end
   end

   assign mode_e = disp_mode_t'(mode);

   always_comb begin
      bar = '0;
      dot = '0;
      for (int i = 0; i < N_LEDS; i++) begin
         bar[i] = (i < int'(level_q));
         dot[i] = (i + 1 == int'(level_q));
      end
      led = bar;
      unique case (mode_e)
         MODE_BAR:       led = bar;
         MODE_DOT:       led = dot;
         MODE_BAR_BLINK: led = too_close ? (bar & {N_LEDS{blink_phase_q}}) : bar;
         MODE_RSVD:      led = bar;
         default:        led = bar;
      endcase
   end

endmodule

// File: tb/tb_distance_bargraph_display.sv
// Scoreboard bench: stimulus pushes model levels, a negedge monitor
// pops them when due and checks level, too_close and the LED pattern.
module tb_distance_bargraph_display;

   localparam int DIST_W    = 22;
   localparam int N_LEDS    = 10;
   localparam int SHIFT     = 18;
   localparam int STEP_LOG2 = 1;
   localparam int AVG_LOG2  = 2;
   localparam int HOLD      = 3;
   localparam int BLINK_DIV = 4;
   localparam int DEPTH     = 1 << AVG_LOG2;
   localparam int LAT       = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sample_valid = 1'b0;
   logic [DIST_W-1:0] distance = '0;
   logic [1:0]        mode = 2'd0;
   logic [N_LEDS-1:0] led;
   logic [3:0]        level;
   logic              too_close;

   distance_bargraph_display #(
      .DIST_W    (DIST_W),
      .N_LEDS    (N_LEDS),
      .SHIFT     (SHIFT),
      .STEP_LOG2 (STEP_LOG2),
      .AVG_LOG2  (AVG_LOG2),
      .HOLD      (HOLD),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .distance     (distance),
      .mode         (mode),
      .led          (led),
      .level        (level),
      .too_close    (too_close)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int due;
      int lvl;
   } exp_t;

   exp_t exp_q[$];

   longint unsigned hist[$];
   int m_lvl = 0;
   int m_cand = 0;
   int m_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      hist.delete();
      m_lvl  = 0;
      m_cand = 0;
      m_cnt  = 0;
   endfunction

   // Window average, distance-to-LED mapping, then hysteresis.
   function automatic int model_level(input longint unsigned d);
      longint unsigned sum, avg, s;
      int raw;
      if (hist.size() == 0) begin
         repeat (DEPTH) hist.push_back(d);
      end else begin
         void'(hist.pop_front());
         hist.push_back(d);
      end
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      avg = sum / DEPTH;
      s   = avg / (longint'(1) << (SHIFT + STEP_LOG2));
      raw = (s < N_LEDS - 1) ? N_LEDS - int'(s) : 1;
      if (m_lvl == 0) begin
         m_lvl = raw;
      end else if (raw - m_lvl >= 2 || m_lvl - raw >= 2) begin
         m_lvl = raw;
         m_cnt = 0;
      end else if (raw == m_lvl) begin
         m_cnt = 0;
      end else begin
         if (raw != m_cand) begin
            m_cand = raw;
            m_cnt  = 1;
         end else begin
            m_cnt++;
         end
         if (m_cnt >= HOLD) begin
            m_lvl = m_cand;
            m_cnt = 0;
         end
      end
      return m_lvl;
   endfunction

   function automatic logic [N_LEDS-1:0] exp_led(input int lvl, input int md,
                                                 input bit phase);
      int pat;
      if (lvl == 0) return '0;
      pat = (1 << lvl) - 1;
      if (md == 1) pat = 1 << (lvl - 1);
      else if (md == 2 && lvl == N_LEDS && !phase) pat = 0;
      return N_LEDS'(pat);
   endfunction

   // Monitor: output changes are due LAT cycles after the sample.
   int cur_lvl = 0;
   int tc_cyc = 0;
   initial begin
      bit phase;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            cur_lvl = 0;
            tc_cyc  = 0;
            chk("rst_level", 32'(level), 32'd0);
            chk("rst_led", 32'(led), 32'd0);
         end else begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
               e = exp_q.pop_front();
               chk("late_update", 32'(cyc), 32'(e.due));
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               e = exp_q.pop_front();
               cur_lvl = e.lvl;
            end
            phase = 1'b1;
            if (cur_lvl == N_LEDS) begin
               phase = ((tc_cyc / BLINK_DIV) % 2) == 0;
               tc_cyc++;
            end else begin
               tc_cyc = 0;
            end
            chk("level", 32'(level), 32'(cur_lvl));
            chk("too_close", 32'(too_close), 32'(cur_lvl == N_LEDS));
            chk("led", 32'(led), 32'(exp_led(cur_lvl, int'(mode), phase)));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [DIST_W-1:0] d);
      exp_t e;
      sample_valid = 1'b1;
      distance     = d;
      e.due = cyc + LAT;
      e.lvl = model_level(longint'(d));
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      sample_valid = 1'b0;
      exp_q.delete();
      model_reset();
      idle(2);
      rst = 1'b0;
   endtask

   int walk;

   initial begin
      idle(1);
      do_reset();

      // Closest distance: full bar three cycles after the sample.
      drive(22'h000000);
      idle(2);
      chk("t1_level", 32'(level), 32'd10);
      chk("t1_led", 32'(led), 32'h3FF);
      chk("t1_close", 32'(too_close), 32'd1);

      // Blinking only while at the top level and in blink mode.
      mode = 2'd2;
      idle(20);
      mode = 2'd0;
      idle(5);

      do_reset();
      drive(22'h200000);
      idle(3);
      chk("t2_level", 32'(level), 32'd6);
      chk("t2_bar", 32'(led), 32'h03F);
      mode = 2'd1;
      idle(1);
      chk("t2_dot", 32'(led), 32'h020);
      mode = 2'd0;

      do_reset();
      drive(22'h200000);
      idle(3);
      for (int i = 0; i < 7; i++) begin
         drive(22'h280000);
         idle(3);
         if (i == 4) chk("t3_held", 32'(level), 32'd6);
         if (i == 5) chk("t3_moved", 32'(led), 32'h01F);
      end

      do_reset();
      drive(22'h200000);
      idle(3);
      drive(22'h000000);
      idle(3);
      chk("t4_hold", 32'(level), 32'd6);
      drive(22'h000000);
      idle(2);
      chk("t4_jump", 32'(level), 32'd8);

      // Asynchronous reset lands between clock edges.
      drive(22'h100000);
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_reset();
      #1;
      chk("t6_async_level", 32'(level), 32'd0);
      chk("t6_async_led", 32'(led), 32'd0);
      idle(2);
      rst = 1'b0;
      // All-ones: step 7 of 9, so three LEDs.
      drive(22'h3FFFFF);
      idle(3);
      chk("t6_level", 32'(level), 32'd3);
      chk("t6_led", 32'(led), 32'h007);

      walk = 22'h200000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 149) == 0) do_reset();
         if ($urandom_range(0, 1) == 0)
            walk = int'($urandom_range(0, 22'h3FFFFF));
         else
            walk = walk + int'($urandom_range(0, 22'h0C0000)) - 22'h060000;
         if (walk < 0) walk = 0;
         if (walk > 22'h3FFFFF) walk = 22'h3FFFFF;
         drive(DIST_W'(walk));
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end

      idle(LAT + 3);
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
